pwd_lock_ctrl: RTL

PWD_LOCK_CTRL -- requirements
Module: pwd_lock_ctrl

---
 rtl/pwd_lock_pkg.sv | 15 +
 rtl/sec_tick.sv | 32 +++
 rtl/pwd_lock_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pwd_lock_pkg.sv
// Shared definitions for the password lock controller.
package pwd_lock_pkg;

  localparam int unsigned STATE_W = 3;

  // Controller state codes; the numeric values are visible on the state port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_SETPW   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: pulses tick every TICK_DIV cycles, the first pulse
// landing so that a consumer registering on tick updates exactly TICK_DIV
// cycles after the restart edge.
module sec_tick #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  // Free-running divider, zeroed on restart; tick is issued one cycle early
  // because the consumer acts on it a cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(TICK_DIV - 2));
      cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Keypad password lock: digit entry with timeout, failure counting with
// timed lockout, and password change while open.
module pwd_lock_ctrl
  import pwd_lock_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned ENTRY_SECS = 10,
  parameter int unsigned LOCK_SECS  = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  key_enter,
  input  logic                  key_clear,
  input  logic                  set_req,
  output logic                  open,
  output logic                  locked,
  output logic [2:0]            state,
  output logic [4*DIGITS-1:0]   entry_buf,
  output logic [3:0]            digit_cnt,
  output logic [7:0]            countdown,
  output logic [3:0]            fail_cnt
);

  localparam int unsigned BW = 4 * DIGITS;

  state_e          state_q, state_d;
  logic [BW-1:0]   pwd_q, pwd_d;
  logic [BW-1:0]   buf_d;
  logic [3:0]      cnt_d;
  logic [7:0]      cd_d;
  logic [3:0]      fail_d;
  logic            tick;
  logic            restart_c;
  logic            fail_c;
  logic [3:0]      fail_inc;
  logic            lock_hit;

  // Single winning key event per cycle: clear > enter > set > digit.
  logic ev_clear, ev_enter, ev_set, digit_ok, full;

  assign ev_clear  = key_clear;
  assign ev_enter  = !key_clear && key_enter;
  assign ev_set    = !key_clear && !key_enter && set_req;
  assign full      = (digit_cnt == 4'(DIGITS));
  assign digit_ok  = !key_clear && !key_enter && !set_req && key_valid &&
                     (key_digit <= 4'd9) && !full;
  assign fail_inc  = fail_cnt + 4'd1;
  assign lock_hit  = (fail_inc == 4'(MAX_TRIES));
  assign state     = state_q;
  assign restart_c = (state_d != state_q);

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    buf_d   = entry_buf;
    cnt_d   = digit_cnt;
    cd_d    = countdown;
    fail_d  = fail_cnt;
    pwd_d   = pwd_q;
    fail_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          state_d = ST_ENTRY;
          buf_d   = BW'(key_digit);
          cnt_d   = 4'd1;
          cd_d    = 8'(ENTRY_SECS);
        end
      end

      ST_ENTRY: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = 4'd0;
          cd_d    = 8'd0;
        end else if (ev_enter && full) begin
          if (entry_buf == pwd_q) begin
            state_d = ST_OPEN;
            buf_d   = '0;
            cnt_d   = 4'd0;
            cd_d    = 8'd0;
            fail_d  = 4'd0;
          end else begin
            fail_c = 1'b1;
          end
        end else begin
          if (digit_ok) begin
            buf_d = (entry_buf << 4) | BW'(key_digit);
            cnt_d = digit_cnt + 4'd1;
          end
          if (tick) begin
            if (countdown <= 8'd1) begin
              fail_c = 1'b1;
            end else begin
              cd_d = countdown - 8'd1;
            end
          end
        end
      end

      ST_OPEN: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          buf_d   = '0;
          cnt_d   = 4'd0;
        end else if (ev_set) begin
          state_d = ST_SETPW;
          buf_d   = '0;
          cnt_d   = 4'd0;
        end
      end

      ST_SETPW: begin
        if (ev_clear) begin
          state_d = ST_OPEN;
          buf_d   = '0;
          cnt_d   = 4'd0;
        end else if (ev_enter && full) begin
          state_d = ST_OPEN;
          pwd_d   = entry_buf;
          buf_d   = '0;
          cnt_d   = 4'd0;
        end else if (digit_ok) begin
          buf_d = (entry_buf << 4) | BW'(key_digit);
          cnt_d = digit_cnt + 4'd1;
        end
      end

      ST_LOCKOUT: begin
        if (tick) begin
          if (countdown <= 8'd1) begin
            state_d = ST_IDLE;
            cd_d    = 8'd0;
            fail_d  = 4'd0;
          end else begin
            cd_d = countdown - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        buf_d   = '0;
        cnt_d   = 4'd0;
        cd_d    = 8'd0;
      end
    endcase

    // A failed attempt (wrong code or timeout) either relocks or locks out.
    if (fail_c) begin
      fail_d = fail_inc;
      buf_d  = '0;
      cnt_d  = 4'd0;
      if (lock_hit) begin
        state_d = ST_LOCKOUT;
        cd_d    = 8'(LOCK_SECS);
      end else begin
        state_d = ST_IDLE;
        cd_d    = 8'd0;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pwd_q     <= '0;
      entry_buf <= '0;
      digit_cnt <= 4'd0;
      countdown <= 8'd0;
      fail_cnt  <= 4'd0;
      open      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwd_q     <= pwd_d;
      entry_buf <= buf_d;
      digit_cnt <= cnt_d;
      countdown <= cd_d;
      fail_cnt  <= fail_d;
      open      <= (state_d == ST_OPEN);
      locked    <= (state_d == ST_LOCKOUT);
    end
  end

endmodule
